hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS datapath. It computes the global `stall` and every forwarding-mux select that the datapath consumes:

- `Fcmp1D` / `Fcmp2D`, also used as `FPCF`.
- `FaluaE` / `FalubE`.
- `FdmdataM`.

It also owns a multi-cycle mult/div busy timer, so instructions that touch HI/LO wait in D until the operation completes. A registered stall-cycle performance counter is included.

## Interface

Parameters:
- `MULT_CYCLES`, 5, E-stage occupancy of mult/multu after issue.
- `DIV_CYCLES`, 10, E-stage occupancy of div/divu after issue.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rs_d`, `rt_d`  in  5 each  source register numbers of the instruction in D.
- `tuse_rs_d`, `tuse_rt_d`  in  2 each  cycles until the operand is needed: 0 = D, 1 = E, 2 = M, 3 = unused.
- `rs_e`, `rt_e`  in  5 each  source register numbers in E.
- `rt_m`  in  5  store-data register in M.
- `rfa3_e`, `rfa3_m`, `rfa3_w`  in  5 each  destination registers (`RFA3E`/`RFA3M`/`RFA3W`).
- `res_e`, `res_m`, `res_w`  in  2 each  result kind: 0 = NW, 1 = ALU, 2 = DM, 3 = PC.
- `md_use_d`  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- `md_start_e`  in  1  E holds a mult/div this cycle.
- `md_is_div_e`  in  1  qualifies `md_start_e`: 1 = div.
- `stall`  out  1  freeze F/D, bubble E.
- `fcmp1_d`, `fcmp2_d`  out  3 each  D-stage forward select.
- `falua_e`, `falub_e`  out  2 each  E-stage forward select.
- `fdm_m`  out  1  M-stage store-data select.
- `md_busy`  out  1  mult/div unit occupied.
- `stall_cnt`  out  32  count of stalled cycles.

## Operation

Forward select encodings:
- D-stage (`fcmp1_d`, `fcmp2_d`): 0 = RF, 1 = RFDATA (W), 2 = AOM, 3 = PC8M, 4 = PC8E.
- E-stage (`falua_e`, `falub_e`): 0 = V, 1 = RFDATA, 2 = AOM, 3 = PC8M.
- M-stage (`fdm_m`): 0 = V2M, 1 = RFDATA.

Register 0 never matches; a source of `$0` always yields select 0.

Forward priority is nearest stage first:
- D operand:
  - E stage: `res_e`==PC → 4.
  - M stage: `res_m`==ALU → 2; `res_m`==PC → 3.
  - W stage: `res_w`!=NW → 1.
  - Otherwise 0.
- E operand:
  - M stage: ALU → 2; PC → 3.
  - W stage: `res_w`!=NW → 1.
  - Otherwise 0.
- `fdm_m` = 1 iff `rt_m`!=0, `rt_m`==`rfa3_w` and `res_w`!=NW.
- A nearer stage matching with a non-forwardable kind blocks farther stages; the stall logic covers that case.

Tnew per stage:
- E: ALU = 1, DM = 2, PC = 0, NW = 0.
- M: DM = 1, all other kinds = 0.
- W: always 0.

Stall conditions:
- Data stall: for each D operand with tuse≠3 and a nonzero register, stall if it matches `rfa3_e` with Tnew_E > tuse, or matches `rfa3_m` with Tnew_M > tuse.
- MD stall: `md_use_d` && `md_busy`.
- `stall` is the OR of the data stall and the MD stall.

MD timer (state IDLE/BUSY, down-counter `md_cnt`, width `$clog2(DIV_CYCLES+1)`):
- IDLE, `md_start_e` → BUSY, `md_cnt` ← (div ? `DIV_CYCLES` : `MULT_CYCLES`) − 1.
- BUSY: decrement each cycle; when `md_cnt`==0 → IDLE.
- `md_start_e` while in BUSY reloads the counter (restart). No saturation or underflow is possible.
- `md_busy` = `md_start_e` | (state==BUSY). It is combinational on start, so the op directly behind mult in D stalls immediately.

`stall_cnt`:
- Increments by 1 on every edge where `stall`=1.
- Saturates at 0xFFFF_FFFF (no wrap).

## Timing

- All select outputs and the data stall are combinational, with zero latency.
- The MD busy window is exactly `MULT_CYCLES` (or `DIV_CYCLES`) cycles counting the start cycle.
- Reset values:
  - state IDLE, `md_cnt` 0, `md_busy` 0, `stall_cnt` 0.
  - With all inputs 0: `stall` 0 and every select 0.
- Reset asserted mid-operation drops BUSY immediately (asynchronous) and clears `stall_cnt`. An `md_start_e` that is high during reset is ignored until release.

## Structure

- Package `hazard_pkg` holds:
  - RES kind constants (NW/ALU/DM/PC).
  - The three forward-select encodings.
  - The Tuse "unused" value 3.
  - `MULT_CYCLES`/`DIV_CYCLES` defaults.
- One sub-module, `md_busy_timer`, contains the IDLE/BUSY FSM and down-counter and outputs `md_busy`.
- Forwarding and stall logic, plus `stall_cnt`, live in `hazard_ctrl`.

## Test plan

- Load-use: `rfa3_e`=8, `res_e`=DM, `rs_d`=8, `tuse_rs_d`=1 → `stall`=1. Next cycle `rfa3_m`=8, `res_m`=DM → `stall`=0 with `tuse`=2 and 1 with `tuse`=0. Then W stage, `res_w`=DM → `fcmp1_d`=1.
- Branch after ALU op:
  - `rfa3_e`=9, `res_e`=ALU, `rt_d`=9, `tuse_rt_d`=0 → `stall`=1.
  - With `rfa3_m`=9, `res_m`=ALU → `stall`=0 and `fcmp2_d`=2.
- Priority: `rfa3_m`=`rfa3_w`=5, `res_m`=PC, `res_w`=ALU, `rs_e`=5 → `falua_e`=3. Any register-0 source → select 0 and no stall.
- Store data: `rt_m`=4, `rfa3_w`=4, `res_w`=DM → `fdm_m`=1; with `rt_m`=0 → 0.
- MD timer:
  - `md_start_e` for one cycle with div=0, `md_use_d`=1 held → `md_busy`/`stall` high for exactly 5 cycles.
  - With div=1 → 10 cycles.
  - Reset pulse in cycle 3 → `md_busy` drops immediately and `stall_cnt`=0.
- Counter: force `stall`=1 for 7 cycles → `stall_cnt`=7. Preload-saturation check: it holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: result kinds,
// forward-select encodings, Tuse sentinel and mult/div latencies.
package hazard_pkg;

  // Result kind of the instruction occupying a stage
  localparam logic [1:0] RES_NW  = 2'd0;
  localparam logic [1:0] RES_ALU = 2'd1;
  localparam logic [1:0] RES_DM  = 2'd2;
  localparam logic [1:0] RES_PC  = 2'd3;

  // D-stage compare/branch operand select
  localparam logic [2:0] FD_RF     = 3'd0;
  localparam logic [2:0] FD_RFDATA = 3'd1;
  localparam logic [2:0] FD_AOM    = 3'd2;
  localparam logic [2:0] FD_PC8M   = 3'd3;
  localparam logic [2:0] FD_PC8E   = 3'd4;

  // E-stage ALU operand select
  localparam logic [1:0] FE_V      = 2'd0;
  localparam logic [1:0] FE_RFDATA = 2'd1;
  localparam logic [1:0] FE_AOM    = 2'd2;
  localparam logic [1:0] FE_PC8M   = 2'd3;

  // M-stage store-data select
  localparam logic FM_V2M    = 1'b0;
  localparam logic FM_RFDATA = 1'b1;

  // Tuse value meaning "operand not read"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // Cycles until a result in E becomes forwardable
  function automatic logic [1:0] tnew_e(input logic [1:0] res);
    case (res)
      RES_ALU: return 2'd1;
      RES_DM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Cycles until a result in M becomes forwardable
  function automatic logic [1:0] tnew_m(input logic [1:0] res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle. The datapath side is the
// master (drives stage info, consumes selects); the controller is the slave.
interface hazard_ctrl_if;
  logic [4:0]  rs_d, rt_d;
  logic [1:0]  tuse_rs_d, tuse_rt_d;
  logic [4:0]  rs_e, rt_e, rt_m;
  logic [4:0]  rfa3_e, rfa3_m, rfa3_w;
  logic [1:0]  res_e, res_m, res_w;
  logic        md_use_d, md_start_e, md_is_div_e;
  logic        stall;
  logic [2:0]  fcmp1_d, fcmp2_d;
  logic [1:0]  falua_e, falub_e;
  logic        fdm_m;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, rs_e, rt_e, rt_m,
           rfa3_e, rfa3_m, rfa3_w, res_e, res_m, res_w,
           md_use_d, md_start_e, md_is_div_e,
    input  stall, fcmp1_d, fcmp2_d, falua_e, falub_e, fdm_m, md_busy, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, rs_e, rt_e, rt_m,
           rfa3_e, rfa3_m, rfa3_w, res_e, res_m, res_w,
           md_use_d, md_start_e, md_is_div_e,
    output stall, fcmp1_d, fcmp2_d, falua_e, falub_e, fdm_m, md_busy, stall_cnt
  );
endinterface

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer. Busy is asserted combinationally in the issue
// cycle and held for exactly MULT_CYCLES/DIV_CYCLES cycles in total.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_i,
  input  logic md_is_div_i,
  output logic md_busy_o
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d, load_val;

  assign load_val = md_is_div_i ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next state: the issue cycle is the first busy cycle, so BUSY lasts for
  // the loaded count and drops on the edge where the counter reaches zero.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (md_start_i) begin
      state_d  = (load_val == '0) ? MD_IDLE : MD_BUSY;
      md_cnt_d = load_val;
    end else if (state_q == MD_BUSY) begin
      if (md_cnt_q <= CW'(1)) begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end else begin
        md_cnt_d = md_cnt_q - CW'(1);
      end
    end
  end

  // A start seen while reset is held must not leak out as busy
  assign md_busy_o = !rst && (md_start_i || state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, data/MD stall
// and a saturating stalled-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  // Nearest matching stage decides; a match that cannot forward yields RF
  // and the stall logic holds D until the value is available.
  function automatic logic [2:0] fwd_d(
    input logic [4:0] r, input logic [4:0] a3e, input logic [1:0] re,
    input logic [4:0] a3m, input logic [1:0] rm,
    input logic [4:0] a3w, input logic [1:0] rw);
    if (r == 5'd0)  return FD_RF;
    if (r == a3e)   return (re == RES_PC) ? FD_PC8E : FD_RF;
    if (r == a3m)   return (rm == RES_ALU) ? FD_AOM : (rm == RES_PC) ? FD_PC8M : FD_RF;
    if (r == a3w)   return (rw != RES_NW) ? FD_RFDATA : FD_RF;
    return FD_RF;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [4:0] r, input logic [4:0] a3m, input logic [1:0] rm,
    input logic [4:0] a3w, input logic [1:0] rw);
    if (r == 5'd0)  return FE_V;
    if (r == a3m)   return (rm == RES_ALU) ? FE_AOM : (rm == RES_PC) ? FE_PC8M : FE_V;
    if (r == a3w)   return (rw != RES_NW) ? FE_RFDATA : FE_V;
    return FE_V;
  endfunction

  function automatic logic op_stall(
    input logic [4:0] r, input logic [1:0] tuse,
    input logic [4:0] a3e, input logic [1:0] re,
    input logic [4:0] a3m, input logic [1:0] rm);
    if (tuse == TUSE_NONE || r == 5'd0) return 1'b0;
    return (r == a3e && tnew_e(re) > tuse) || (r == a3m && tnew_m(rm) > tuse);
  endfunction

  logic        data_stall, md_busy, stall;
  logic [31:0] stall_cnt_q;

  md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk         (clk),
    .rst         (reset),
    .md_start_i  (hz.md_start_e),
    .md_is_div_i (hz.md_is_div_e),
    .md_busy_o   (md_busy)
  );

  // Forward selects and stall, all zero-latency
  always_comb begin
    hz.fcmp1_d = fwd_d(hz.rs_d, hz.rfa3_e, hz.res_e, hz.rfa3_m, hz.res_m, hz.rfa3_w, hz.res_w);
    hz.fcmp2_d = fwd_d(hz.rt_d, hz.rfa3_e, hz.res_e, hz.rfa3_m, hz.res_m, hz.rfa3_w, hz.res_w);
    hz.falua_e = fwd_e(hz.rs_e, hz.rfa3_m, hz.res_m, hz.rfa3_w, hz.res_w);
    hz.falub_e = fwd_e(hz.rt_e, hz.rfa3_m, hz.res_m, hz.rfa3_w, hz.res_w);
    hz.fdm_m   = (hz.rt_m != 5'd0 && hz.rt_m == hz.rfa3_w && hz.res_w != RES_NW)
                 ? FM_RFDATA : FM_V2M;
    data_stall = op_stall(hz.rs_d, hz.tuse_rs_d, hz.rfa3_e, hz.res_e, hz.rfa3_m, hz.res_m)
               | op_stall(hz.rt_d, hz.tuse_rt_d, hz.rfa3_e, hz.res_e, hz.rfa3_m, hz.res_m);
    stall      = data_stall | (hz.md_use_d & md_busy);
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1)  stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hz.stall     = stall;
  assign hz.md_busy   = md_busy;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, MD timer / counter
// sequences, and randomized stage contents against a stage-walk model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();
  hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hif));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0] rs_d, rt_d;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] rs_e, rt_e, rt_m, a3e, a3m, a3w;
    logic [1:0] re, rm, rw;
    logic       x_stall;
    logic [2:0] x_f1, x_f2;
    logic [1:0] x_fa, x_fb;
    logic       x_fdm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    hif.rs_d = 0; hif.rt_d = 0; hif.tuse_rs_d = 0; hif.tuse_rt_d = 0;
    hif.rs_e = 0; hif.rt_e = 0; hif.rt_m = 0;
    hif.rfa3_e = 0; hif.rfa3_m = 0; hif.rfa3_w = 0;
    hif.res_e = 0; hif.res_m = 0; hif.res_w = 0;
    hif.md_use_d = 0; hif.md_start_e = 0; hif.md_is_div_e = 0;
  endtask

  task automatic apply(input vec_t v);
    hif.rs_d = v.rs_d; hif.rt_d = v.rt_d; hif.tuse_rs_d = v.tu_rs; hif.tuse_rt_d = v.tu_rt;
    hif.rs_e = v.rs_e; hif.rt_e = v.rt_e; hif.rt_m = v.rt_m;
    hif.rfa3_e = v.a3e; hif.rfa3_m = v.a3m; hif.rfa3_w = v.a3w;
    hif.res_e = v.re; hif.res_m = v.rm; hif.res_w = v.rw;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Forward code offered by each stage (E, M, W) for each result kind
  // (NW, ALU, DM, PC); 0 means "cannot forward yet".
  int fcode[3][4] = '{'{0, 0, 0, 4}, '{0, 2, 0, 3}, '{0, 1, 1, 1}};
  // Cycles until each kind is ready when sitting in E / M
  int tnew[2][4]  = '{'{0, 1, 2, 0}, '{0, 0, 1, 0}};

  function automatic int m_fwd(input int r, input int first);
    int a[3];
    int k[3];
    a = '{int'(hif.rfa3_e), int'(hif.rfa3_m), int'(hif.rfa3_w)};
    k = '{int'(hif.res_e), int'(hif.res_m), int'(hif.res_w)};
    if (r == 0) return 0;
    for (int s = first; s < 3; s++)
      if (r == a[s]) return fcode[s][k[s]];
    return 0;
  endfunction

  function automatic bit m_stall_op(input int r, input int tu);
    int a[2];
    int k[2];
    a = '{int'(hif.rfa3_e), int'(hif.rfa3_m)};
    k = '{int'(hif.res_e), int'(hif.res_m)};
    if (tu == 3 || r == 0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (r == a[s] && tnew[s][k[s]] > tu) return 1'b1;
    return 1'b0;
  endfunction

  int busy_n;
  int exp_cnt;
  vec_t v;

  task automatic md_run(input logic div, input int exp_n);
    do_reset();
    @(negedge clk);
    hif.md_use_d = 1'b1; hif.md_start_e = 1'b1; hif.md_is_div_e = div;
    busy_n = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (hif.md_busy === 1'b1 && hif.stall === 1'b1) busy_n++;
      @(negedge clk);
      hif.md_start_e = 1'b0;
    end
    chk(div ? "div_window" : "mult_window", busy_n, exp_n);
    chk(div ? "div_stall_cnt" : "mult_stall_cnt", hif.stall_cnt, exp_n);
    chk("md_idle_after", {31'd0, hif.md_busy}, 0);
    hif.md_use_d = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    #7;
    chk("rst_md_busy",   {31'd0, hif.md_busy}, 0);
    chk("rst_stall_cnt", hif.stall_cnt, 0);
    chk("rst_outputs", {hif.stall, hif.fcmp1_d, hif.fcmp2_d, hif.falua_e, hif.falub_e, hif.fdm_m}, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- directed vector table ----
    for (int i = 0; i < 16; i++) begin vecs[i] = '0; vecs[i].tu_rt = 3; end
    // load-use in E
    vecs[1].a3e = 8; vecs[1].re = RES_DM; vecs[1].rs_d = 8; vecs[1].tu_rs = 1; vecs[1].x_stall = 1;
    // load in M, consumer needs it in M stage
    vecs[2].a3m = 8; vecs[2].rm = RES_DM; vecs[2].rs_d = 8; vecs[2].tu_rs = 2;
    // load in M, branch consumer
    vecs[3].a3m = 8; vecs[3].rm = RES_DM; vecs[3].rs_d = 8; vecs[3].tu_rs = 0; vecs[3].x_stall = 1;
    // load in W forwards RFDATA
    vecs[4].a3w = 8; vecs[4].rw = RES_DM; vecs[4].rs_d = 8; vecs[4].tu_rs = 1; vecs[4].x_f1 = 1;
    // branch after ALU op in E
    vecs[5].a3e = 9; vecs[5].re = RES_ALU; vecs[5].rt_d = 9; vecs[5].tu_rt = 0; vecs[5].x_stall = 1;
    // ALU result in M forwards AOM to branch
    vecs[6].a3m = 9; vecs[6].rm = RES_ALU; vecs[6].rt_d = 9; vecs[6].tu_rt = 0; vecs[6].x_f2 = 2;
    // M PC beats W ALU for the E operand
    vecs[7].a3m = 5; vecs[7].rm = RES_PC; vecs[7].a3w = 5; vecs[7].rw = RES_ALU; vecs[7].rs_e = 5; vecs[7].x_fa = 3;
    // register 0 never forwards or stalls
    vecs[8].a3e = 0; vecs[8].re = RES_DM; vecs[8].a3m = 0; vecs[8].rm = RES_ALU; vecs[8].a3w = 0; vecs[8].rw = RES_ALU;
    vecs[8].tu_rt = 0;
    // store data from W
    vecs[9].rt_m = 4; vecs[9].a3w = 4; vecs[9].rw = RES_DM; vecs[9].x_fdm = 1;
    vecs[10].rt_m = 0; vecs[10].a3w = 0; vecs[10].rw = RES_DM;
    // jal in E forwards PC8E
    vecs[11].a3e = 3; vecs[11].re = RES_PC; vecs[11].rs_d = 3; vecs[11].tu_rs = 0; vecs[11].x_f1 = 4;
    // W forward to E operand b
    vecs[12].a3w = 7; vecs[12].rw = RES_ALU; vecs[12].rt_e = 7; vecs[12].x_fb = 1;
    // M load blocks the W forward
    vecs[13].a3m = 6; vecs[13].rm = RES_DM; vecs[13].a3w = 6; vecs[13].rw = RES_ALU; vecs[13].rt_e = 6;
    // unused operand never stalls
    vecs[14].a3e = 8; vecs[14].re = RES_DM; vecs[14].rs_d = 8; vecs[14].tu_rs = 3;
    // ALU in E blocks W for D, both operands
    vecs[15].a3e = 2; vecs[15].re = RES_ALU; vecs[15].a3w = 2; vecs[15].rw = RES_ALU;
    vecs[15].rs_d = 2; vecs[15].tu_rs = 1; vecs[15].rt_d = 2; vecs[15].tu_rt = 2;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      v = vecs[i];
      chk($sformatf("vec%0d.stall", i), {31'd0, hif.stall}, {31'd0, v.x_stall});
      chk($sformatf("vec%0d.fwd", i),
          {20'd0, hif.fcmp1_d, hif.fcmp2_d, hif.falua_e, hif.falub_e, hif.fdm_m},
          {20'd0, v.x_f1, v.x_f2, v.x_fa, v.x_fb, v.x_fdm});
    end

    // ---- MD timer windows ----
    md_run(1'b0, 5);
    md_run(1'b1, 10);

    // ---- reset in the middle of a div ----
    do_reset();
    @(negedge clk);
    hif.md_use_d = 1'b1; hif.md_start_e = 1'b1; hif.md_is_div_e = 1'b1;
    @(negedge clk); hif.md_start_e = 1'b0;
    @(negedge clk);
    #2;
    chk("md_busy_before_rst", {31'd0, hif.md_busy}, 1);
    reset = 1'b1;
    #1;
    chk("md_busy_async_rst", {31'd0, hif.md_busy}, 0);
    chk("stall_cnt_async_rst", hif.stall_cnt, 0);
    hif.md_start_e = 1'b1;
    #1;
    chk("md_start_in_rst", {31'd0, hif.md_busy}, 0);
    @(negedge clk);
    hif.md_start_e = 1'b0;
    reset = 1'b0;
    #1;
    chk("md_idle_after_rst", {31'd0, hif.md_busy}, 0);
    hif.md_use_d = 1'b0;

    // ---- stall counter: 7 stalled cycles ----
    do_reset();
    @(negedge clk);
    hif.rfa3_e = 8; hif.res_e = RES_DM; hif.rs_d = 8; hif.tuse_rs_d = 1; hif.tuse_rt_d = 3;
    repeat (7) @(negedge clk);
    clear_in();
    #1;
    chk("stall_cnt_7", hif.stall_cnt, 7);

    // ---- saturation from a preloaded value ----
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    hif.rfa3_e = 8; hif.res_e = RES_DM; hif.rs_d = 8; hif.tuse_rs_d = 1; hif.tuse_rt_d = 3;
    repeat (4) @(negedge clk);
    #1;
    chk("stall_cnt_sat", hif.stall_cnt, 32'hFFFF_FFFF);
    clear_in();

    // ---- randomized stage contents vs model ----
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hif.rs_d = 5'($urandom_range(0, 3)); hif.rt_d = 5'($urandom_range(0, 3));
      hif.tuse_rs_d = 2'($urandom_range(0, 3)); hif.tuse_rt_d = 2'($urandom_range(0, 3));
      hif.rs_e = 5'($urandom_range(0, 3)); hif.rt_e = 5'($urandom_range(0, 3));
      hif.rt_m = 5'($urandom_range(0, 3));
      hif.res_e = 2'($urandom_range(0, 3)); hif.res_m = 2'($urandom_range(0, 3));
      hif.res_w = 2'($urandom_range(0, 3));
      // a non-writing instruction carries no destination
      hif.rfa3_e = (hif.res_e == RES_NW) ? 5'd0 : 5'($urandom_range(0, 3));
      hif.rfa3_m = (hif.res_m == RES_NW) ? 5'd0 : 5'($urandom_range(0, 3));
      hif.rfa3_w = (hif.res_w == RES_NW) ? 5'd0 : 5'($urandom_range(0, 3));
      #1;
      begin
        bit s;
        int fdm;
        s = m_stall_op(hif.rs_d, hif.tuse_rs_d) || m_stall_op(hif.rt_d, hif.tuse_rt_d);
        fdm = (hif.rt_m != 0 && hif.rt_m == hif.rfa3_w && hif.res_w != RES_NW) ? 1 : 0;
        chk("rnd.stall",   {31'd0, hif.stall}, s);
        chk("rnd.fcmp1_d", {29'd0, hif.fcmp1_d}, m_fwd(hif.rs_d, 0));
        chk("rnd.fcmp2_d", {29'd0, hif.fcmp2_d}, m_fwd(hif.rt_d, 0));
        chk("rnd.falua_e", {30'd0, hif.falua_e}, m_fwd(hif.rs_e, 1));
        chk("rnd.falub_e", {30'd0, hif.falub_e}, m_fwd(hif.rt_e, 1));
        chk("rnd.fdm_m",   {31'd0, hif.fdm_m}, fdm);
        if (s) exp_cnt++;
      end
    end
    @(negedge clk);
    clear_in();
    #1;
    chk("rnd.stall_cnt", hif.stall_cnt, exp_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
